// File: rtl/rodadas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rodadas_pkg
// Description : State codes and defaults shared by the progressive-rounds
//               memory-game control unit and its timeout timer.
// Revision    : 1.0 - initial release
// ============================================================================
package rodadas_pkg;

  // Default number of cycles a player has to make each move
  localparam int unsigned c_timeout_cycles_default = 5000;

  // 4-bit state codes; these values are also what db_estado shows
  localparam logic [3:0] c_est_inicial        = 4'h0;
  localparam logic [3:0] c_est_preparacao     = 4'h1;
  localparam logic [3:0] c_est_inicia_rodada  = 4'h2;
  localparam logic [3:0] c_est_espera         = 4'h3;
  localparam logic [3:0] c_est_registra       = 4'h4;
  localparam logic [3:0] c_est_comparacao     = 4'h5;
  localparam logic [3:0] c_est_proximo        = 4'h6;
  localparam logic [3:0] c_est_proxima_rodada = 4'h7;
  localparam logic [3:0] c_est_estouro        = 4'hC;
  localparam logic [3:0] c_est_vitoria        = 4'hD;
  localparam logic [3:0] c_est_derrota        = 4'hE;
  // Debug code shown when the state register holds an unused encoding
  localparam logic [3:0] c_est_invalido       = 4'hF;

  typedef enum logic [3:0] {
    st_inicial        = c_est_inicial,
    st_preparacao     = c_est_preparacao,
    st_inicia_rodada  = c_est_inicia_rodada,
    st_espera         = c_est_espera,
    st_registra       = c_est_registra,
    st_comparacao     = c_est_comparacao,
    st_proximo        = c_est_proximo,
    st_proxima_rodada = c_est_proxima_rodada,
    st_estouro        = c_est_estouro,
    st_vitoria        = c_est_vitoria,
    st_derrota        = c_est_derrota
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/rodadas_unidade_controle_timer.sv
`default_nettype none
// ============================================================================
// Module      : timer_espera
// Description : Per-move timeout counter. Counts while enabled, clears while
//               zera is high; fim flags the last cycle of the window.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_espera #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic conta,
  input  logic zera,
  output logic fim
);

  logic [TW-1:0] r_count;

  // Cycle counter; never needs to wrap because the FSM leaves espera at fim
  always_ff @(posedge clock) begin
    if (!reset || zera) begin
      r_count <= '0;
    end else if (conta) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign fim = (r_count == TW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/rodadas_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module      : rodadas_unidade_controle
// Description : Moore control unit for the progressive-rounds memory game.
//               Sequences the E/L counters and R register, replays moves
//               against memory up to the round limit, with a per-move timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rodadas_unidade_controle
  import rodadas_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_timeout_cycles_default,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t r_estado;
  estado_t w_proximo;
  logic    w_conta_timer;
  logic    w_fim_timer;

  // The move window only runs in espera, so any other state restarts it
  assign w_conta_timer = (r_estado == st_espera);

  timer_espera #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .conta (w_conta_timer),
    .zera  (!w_conta_timer),
    .fim   (w_fim_timer)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= st_inicial;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Next-state logic; a move in the last timer cycle takes priority
  always_comb begin
    w_proximo = st_inicial;
    case (r_estado)
      st_inicial:        w_proximo = iniciar ? st_preparacao : st_inicial;
      st_preparacao:     w_proximo = st_inicia_rodada;
      st_inicia_rodada:  w_proximo = st_espera;
      st_espera: begin
        if (jogada)           w_proximo = st_registra;
        else if (w_fim_timer) w_proximo = st_estouro;
        else                  w_proximo = st_espera;
      end
      st_registra:       w_proximo = st_comparacao;
      st_comparacao: begin
        if (!igual)                           w_proximo = st_derrota;
        else if (enderecoIgualLimite && fimL) w_proximo = st_vitoria;
        else if (enderecoIgualLimite)         w_proximo = st_proxima_rodada;
        else                                  w_proximo = st_proximo;
      end
      st_proximo:        w_proximo = st_espera;
      st_proxima_rodada: w_proximo = st_inicia_rodada;
      st_estouro,
      st_vitoria,
      st_derrota:        w_proximo = iniciar ? st_preparacao : r_estado;
      default:           w_proximo = st_inicial;
    endcase
  end

  // Moore output decode
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = c_est_invalido;
    case (r_estado)
      st_inicial: begin
        zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; db_estado = c_est_inicial;
      end
      st_preparacao: begin
        zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; db_estado = c_est_preparacao;
      end
      st_inicia_rodada: begin
        zeraE = 1'b1; db_estado = c_est_inicia_rodada;
      end
      st_espera:         db_estado = c_est_espera;
      st_registra: begin
        registraR = 1'b1; db_estado = c_est_registra;
      end
      st_comparacao:     db_estado = c_est_comparacao;
      st_proximo: begin
        contaE = 1'b1; db_estado = c_est_proximo;
      end
      st_proxima_rodada: begin
        contaL = 1'b1; db_estado = c_est_proxima_rodada;
      end
      st_estouro: begin
        pronto = 1'b1; timeout = 1'b1; db_estado = c_est_estouro;
      end
      st_vitoria: begin
        pronto = 1'b1; acertou = 1'b1; db_estado = c_est_vitoria;
      end
      st_derrota: begin
        pronto = 1'b1; errou = 1'b1; db_estado = c_est_derrota;
      end
      default:           db_estado = c_est_invalido;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rodadas_unidade_controle.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rodadas_unidade_controle
// Description : Scoreboard bench for the rounds control unit. Stimulus pushes
//               expected state/pulse-count entries tagged with the sampling
//               cycle; a monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rodadas_unidade_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b0;
  logic       enderecoIgualLimite = 1'b0;
  logic       fimL = 1'b0;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  rodadas_unidade_controle #(.TIMEOUT_CYCLES(8), .TW(3)) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .jogada              (jogada),
    .igual               (igual),
    .enderecoIgualLimite (enderecoIgualLimite),
    .fimL                (fimL),
    .zeraE               (zeraE),
    .contaE              (contaE),
    .zeraL               (zeraL),
    .contaL              (contaL),
    .zeraR               (zeraR),
    .registraR           (registraR),
    .pronto              (pronto),
    .acertou             (acertou),
    .errou               (errou),
    .timeout             (timeout),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  // kind 0: state+outputs, 1: clear pulse counters, 2: check pulse counters
  typedef struct {
    int unsigned cyc;
    int          kind;
    string       nm;
    logic [3:0]  est;
    int          ne;
    int          nl;
    int          nr;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc_n = 0;
  int          errors = 0;
  int          checks = 0;
  bit          done = 1'b0;

  // Hand-written Moore table:
  // {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,acertou,errou,timeout}
  function automatic logic [9:0] outs_for(input logic [3:0] s);
    case (s)
      4'h0, 4'h1: return 10'b1010100000;
      4'h2:       return 10'b1000000000;
      4'h4:       return 10'b0000010000;
      4'h6:       return 10'b0100000000;
      4'h7:       return 10'b0001000000;
      4'hC:       return 10'b0000001001;
      4'hD:       return 10'b0000001100;
      4'hE:       return 10'b0000001010;
      default:    return 10'b0000000000;
    endcase
  endfunction

  task automatic push(input int kind, input string nm, input logic [3:0] est,
                      input int ne, input int nl, input int nr);
    exp_t e;
    e.cyc = cyc_n + 1; e.kind = kind; e.nm = nm; e.est = est;
    e.ne = ne; e.nl = nl; e.nr = nr;
    q.push_back(e);
  endtask

  // Advance one edge and expect the given state afterwards
  task automatic tick(input logic [3:0] est, input string nm);
    @(posedge clock);
    #1;
    push(0, nm, est, 0, 0, 0);
  endtask

  task automatic start_game(input string nm);
    iniciar = 1'b1; tick(4'h1, {nm, " preparacao"});
    iniciar = 1'b0; tick(4'h2, {nm, " inicia_rodada"});
    tick(4'h3, {nm, " espera"});
  endtask

  // One player move: idle cycles in espera, the jogada pulse, the decision
  task automatic move(input int idle, input logic ig, input logic eil,
                      input logic fl, input logic [3:0] dec, input string nm);
    for (int i = 0; i < idle; i++) tick(4'h3, {nm, " idle"});
    jogada = 1'b1; igual = ig; enderecoIgualLimite = eil; fimL = fl;
    tick(4'h4, {nm, " registra"});
    jogada = 1'b0;
    tick(4'h5, {nm, " comparacao"});
    tick(dec, {nm, " decisao"});
    if (dec == 4'h6) begin
      tick(4'h3, {nm, " back to espera"});
    end else if (dec == 4'h7) begin
      tick(4'h2, {nm, " new round"});
      tick(4'h3, {nm, " espera"});
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int   ne = 0;
    int   nl = 0;
    int   nr = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      cyc_n++;
      if (contaE === 1'b1) ne++;
      if (contaL === 1'b1) nl++;
      if (registraR === 1'b1) nr++;
      while (q.size() > 0 && q[0].cyc <= cyc_n) begin
        e = q.pop_front();
        if (e.cyc < cyc_n) begin
          checks++; errors++;
          $display("FAIL %s: entry for cycle %0d seen at cycle %0d", e.nm, e.cyc, cyc_n);
        end else if (e.kind == 1) begin
          ne = 0; nl = 0; nr = 0;
        end else if (e.kind == 2) begin
          checks++;
          if (ne !== e.ne || nl !== e.nl || nr !== e.nr) begin
            errors++;
            $display("FAIL %s: pulses contaE/contaL/registraR got %0d/%0d/%0d expected %0d/%0d/%0d",
                     e.nm, ne, nl, nr, e.ne, e.nl, e.nr);
          end
        end else begin
          checks++;
          if (db_estado !== e.est) begin
            errors++;
            $display("FAIL %s: db_estado got %h expected %h", e.nm, db_estado, e.est);
          end
          checks++;
          if ({zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout}
              !== outs_for(e.est)) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", e.nm,
                     {zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout},
                     outs_for(e.est));
          end
        end
      end
      if (done && q.size() == 0) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    // Reset held for two edges
    tick(4'h0, "reset edge1");
    tick(4'h0, "reset edge2");
    reset = 1'b1;
    tick(4'h0, "idle in inicial");

    // Three-round win
    start_game("win start");
    push(1, "clear counters", 4'h0, 0, 0, 0);
    move(0, 1'b1, 1'b1, 1'b0, 4'h7, "r1 m1");
    move(0, 1'b1, 1'b0, 1'b0, 4'h6, "r2 m1");
    move(0, 1'b1, 1'b1, 1'b0, 4'h7, "r2 m2");
    move(0, 1'b1, 1'b0, 1'b1, 4'h6, "r3 m1");
    move(1, 1'b1, 1'b0, 1'b1, 4'h6, "r3 m2");
    move(0, 1'b1, 1'b1, 1'b1, 4'hD, "r3 m3");
    push(2, "win pulse counts", 4'h0, 3, 2, 6);
    tick(4'hD, "vitoria holds");

    // Wrong move in round 2
    fimL = 1'b0;
    start_game("loss start");
    move(0, 1'b1, 1'b1, 1'b0, 4'h7, "loss r1 m1");
    move(0, 1'b1, 1'b0, 1'b0, 4'h6, "loss r2 m1");
    move(0, 1'b0, 1'b0, 1'b0, 4'hE, "loss r2 m2 wrong");
    tick(4'hE, "derrota holds");

    // Timeout: eight cycles in espera then estouro
    start_game("timeout start");
    for (int i = 0; i < 7; i++) tick(4'h3, "timeout window");
    tick(4'hC, "estouro");
    tick(4'hC, "estouro holds");

    // Move on the 8th cycle wins over the timeout, then timer restarts
    start_game("late move start");
    move(7, 1'b1, 1'b0, 1'b0, 4'h6, "move on last cycle");
    for (int i = 0; i < 7; i++) tick(4'h3, "restarted window");
    tick(4'hC, "estouro after restart");

    // Reset in the middle of comparacao
    start_game("midreset start");
    jogada = 1'b1; igual = 1'b1;
    tick(4'h4, "midreset registra");
    jogada = 1'b0;
    tick(4'h5, "midreset comparacao");
    reset = 1'b0;
    tick(4'h0, "midreset inicial");
    reset = 1'b1;
    tick(4'h0, "after reset stays");
    start_game("post reset start");
    for (int i = 0; i < 7; i++) tick(4'h3, "post reset window");
    tick(4'hC, "post reset estouro");

    done = 1'b1;
    repeat (20) @(posedge clock);
    $display("FAIL drain: %0d expectations never reached", q.size());
    $fatal(1, "scoreboard did not drain");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
